// File: rtl/lcd_i2c_nibbler_if.sv
// Backpack-byte valid/ready channel from the LCD nibbler to the I2C master.
interface lcd_i2c_nibbler_if;
   logic       i2c_valid;
   logic       i2c_ready;
   logic [6:0] i2c_addr;
   logic [7:0] i2c_data;

   modport master (output i2c_valid, output i2c_addr, output i2c_data, input i2c_ready);
   modport slave  (input i2c_valid, input i2c_addr, input i2c_data, output i2c_ready);
endinterface

// File: rtl/lcd_i2c_nibbler.sv
// HD44780 4-bit init and command nibbler that feeds PCF8574 backpack bytes to an I2C master.
// Optional cursor tracking with auto line-wrap is enabled by LCD_CURSOR_TRACK_EN.
module lcd_i2c_nibbler #(
   parameter logic [6:0]  I2C_ADDR  = 7'h27,
   parameter bit          BACKLIGHT = 1'b1,
   parameter int unsigned PWRUP_CYC = 4000000,
   parameter int unsigned INIT_CYC  = 250000,
   parameter int unsigned CMD_CYC   = 2500,
   parameter int unsigned CLR_CYC   = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rs,
   input  logic [7:0]        cmd_byte,
   lcd_i2c_nibbler_if.master i2c,
   output logic              init_done
`ifdef LCD_CURSOR_TRACK_EN
   ,
   output logic [0:0]        cur_row,
   output logic [3:0]        cur_col
`endif
);

   localparam int unsigned MAX_AB  = (PWRUP_CYC > INIT_CYC) ? PWRUP_CYC : INIT_CYC;
   localparam int unsigned MAX_CD  = (CMD_CYC > CLR_CYC) ? CMD_CYC : CLR_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CW      = $clog2(MAX_CYC) + 1;
   localparam int unsigned N_INIT  = 8;

   localparam logic [CW-1:0] D_PWRUP = CW'(PWRUP_CYC);
   localparam logic [CW-1:0] D_INIT  = CW'(INIT_CYC);
   localparam logic [CW-1:0] D_CMD   = CW'(CMD_CYC);
   localparam logic [CW-1:0] D_CLR   = CW'(CLR_CYC);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {ST_PWRUP, ST_SEND, ST_WAIT, ST_IDLE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_dly;
   logic [7:0]    r_byte;
   logic          r_rs;
   logic          r_nib;
   logic [1:0]    r_xfer;
   logic [3:0]    r_step;
   logic          r_cmd_ready;
   logic          r_init_done;
   logic          r_i2c_valid;
   logic [7:0]    r_i2c_data;
`ifdef LCD_CURSOR_TRACK_EN
   logic [0:0]    r_row;
   logic [3:0]    r_col;
   logic          r_auto_pend;
   logic          w_go_auto;
`endif

   logic [7:0]    w_step_byte;
   logic          w_step_nib;
   logic [CW-1:0] w_step_dly;
   logic          w_go;
   logic          w_go_init;
   logic [7:0]    w_go_byte;
   logic          w_go_rs;
   logic          w_go_nib;
   logic [CW-1:0] w_go_dly;
   logic          w_to_idle;
   logic          w_accept;
   logic          w_hs;
   logic          w_last;
   logic [1:0]    w_next_xfer;
   logic [7:0]    w_next_data;

   assign cmd_ready     = r_cmd_ready;
   assign init_done     = r_init_done;
   assign i2c.i2c_valid = r_i2c_valid;
   assign i2c.i2c_data  = r_i2c_data;
   assign i2c.i2c_addr  = I2C_ADDR;
`ifdef LCD_CURSOR_TRACK_EN
   assign cur_row = r_row;
   assign cur_col = r_col;
`endif

   // Power-up init table; nibble-only steps carry their nibble in the high half.
   always_comb begin
      w_step_byte = 8'h00;
      w_step_nib  = 1'b0;
      w_step_dly  = D_CMD;
      case (r_step)
         4'd0: begin w_step_byte = 8'h30; w_step_nib = 1'b1; w_step_dly = D_INIT; end
         4'd1: begin w_step_byte = 8'h30; w_step_nib = 1'b1; w_step_dly = D_INIT; end
         4'd2: begin w_step_byte = 8'h30; w_step_nib = 1'b1; end
         4'd3: begin w_step_byte = 8'h20; w_step_nib = 1'b1; end
         4'd4: w_step_byte = 8'h28;
         4'd5: w_step_byte = 8'h0C;
         4'd6: begin w_step_byte = 8'h01; w_step_dly = D_CLR; end
         4'd7: w_step_byte = 8'h06;
         default: ;
      endcase
   end

   // Launch selection: next init step, cursor auto-command, or a user command.
   always_comb begin
      w_go      = 1'b0;
      w_go_init = 1'b0;
      w_go_byte = w_step_byte;
      w_go_rs   = 1'b0;
      w_go_nib  = w_step_nib;
      w_go_dly  = w_step_dly;
      w_to_idle = 1'b0;
      w_accept  = 1'b0;
`ifdef LCD_CURSOR_TRACK_EN
      w_go_auto = 1'b0;
`endif
      case (r_state)
         ST_PWRUP: begin
            if (r_cnt == '0) begin
               w_go      = 1'b1;
               w_go_init = 1'b1;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               if (r_step != 4'(N_INIT)) begin
                  w_go      = 1'b1;
                  w_go_init = 1'b1;
               end
`ifdef LCD_CURSOR_TRACK_EN
               else if (r_auto_pend) begin
                  w_go      = 1'b1;
                  w_go_auto = 1'b1;
                  w_go_byte = {1'b1, r_row, 6'b0};
                  w_go_nib  = 1'b0;
                  w_go_dly  = D_CMD;
               end
`endif
               else begin
                  w_to_idle = 1'b1;
               end
            end
         end
         ST_IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_go      = 1'b1;
               w_accept  = 1'b1;
               w_go_byte = cmd_byte;
               w_go_rs   = cmd_rs;
               w_go_nib  = 1'b0;
               w_go_dly  = (!cmd_rs && (cmd_byte inside {8'h01, 8'h02, 8'h03})) ? D_CLR : D_CMD;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_hs        = (r_state == ST_SEND) && r_i2c_valid && i2c.i2c_ready;
      w_last      = r_nib ? (r_xfer == 2'd1) : (r_xfer == 2'd3);
      w_next_xfer = r_xfer + 2'd1;
      w_next_data = {(w_next_xfer[1] ? r_byte[3:0] : r_byte[7:4]), BACKLIGHT,
                     ~w_next_xfer[0], 1'b0, r_rs};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_PWRUP;
         r_cnt       <= D_PWRUP - CNT_ONE;
         r_dly       <= '0;
         r_byte      <= '0;
         r_rs        <= 1'b0;
         r_nib       <= 1'b0;
         r_xfer      <= '0;
         r_step      <= '0;
         r_cmd_ready <= 1'b0;
         r_init_done <= 1'b0;
         r_i2c_valid <= 1'b0;
         r_i2c_data  <= '0;
`ifdef LCD_CURSOR_TRACK_EN
         r_row       <= '0;
         r_col       <= '0;
         r_auto_pend <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_PWRUP: begin
               if (r_cnt != '0) r_cnt <= r_cnt - CNT_ONE;
            end
            ST_SEND: begin
               if (w_hs) begin
                  if (w_last) begin
                     r_i2c_valid <= 1'b0;
                     r_cnt       <= r_dly - CNT_ONE;
                     r_state     <= ST_WAIT;
                  end else begin
                     r_xfer     <= w_next_xfer;
                     r_i2c_data <= w_next_data;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_ONE;
               end else if (w_to_idle) begin
                  r_state     <= ST_IDLE;
                  r_cmd_ready <= 1'b1;
                  r_init_done <= 1'b1;
               end
            end
            ST_IDLE: begin
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
`ifdef LCD_CURSOR_TRACK_EN
                  // Data advances the column; wrapping flags a line-address refresh.
                  if (cmd_rs) begin
                     if (r_col == 4'd15) begin
                        r_col       <= '0;
                        r_row       <= ~r_row;
                        r_auto_pend <= 1'b1;
                     end else begin
                        r_col <= r_col + 4'd1;
                     end
                  end else if (cmd_byte[7]) begin
                     r_row <= cmd_byte[6];
                     r_col <= cmd_byte[3:0];
                  end else if (cmd_byte inside {8'h01, 8'h02, 8'h03}) begin
                     r_row <= '0;
                     r_col <= '0;
                  end
`endif
               end
            end
            default: r_state <= ST_PWRUP;
         endcase

         if (w_go) begin
            r_state     <= ST_SEND;
            r_i2c_valid <= 1'b1;
            r_i2c_data  <= {w_go_byte[7:4], BACKLIGHT, 1'b1, 1'b0, w_go_rs};
            r_byte      <= w_go_byte;
            r_rs        <= w_go_rs;
            r_nib       <= w_go_nib;
            r_dly       <= w_go_dly;
            r_xfer      <= '0;
            if (w_go_init) r_step <= r_step + 4'd1;
`ifdef LCD_CURSOR_TRACK_EN
            if (w_go_auto) r_auto_pend <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_lcd_i2c_nibbler.sv
// Self-checking bench for lcd_i2c_nibbler: init sequence, vector table, backpressure, reset, random commands.
// Cursor-wrap checks are included when LCD_CURSOR_TRACK_EN is defined.
module tb_lcd_i2c_nibbler;
   localparam int PWRUP = 20;
   localparam int INITC = 10;
   localparam int CMDC  = 4;
   localparam int CLRC  = 8;
   localparam int LIMIT = 400;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_rs = 1'b0;
   logic [7:0] cmd_byte = 8'h00;
   logic       cmd_ready;
   logic       init_done;
`ifdef LCD_CURSOR_TRACK_EN
   logic [0:0] cur_row;
   logic [3:0] cur_col;
   int         m_row = 0;
   int         m_col = 0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   int init_b[8]   = '{'h30, 'h30, 'h30, 'h20, 'h28, 'h0C, 'h01, 'h06};
   int init_nib[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
   int init_dly[8] = '{INITC, INITC, CMDC, CMDC, CMDC, CMDC, CLRC, CMDC};

   typedef struct {
      logic       rs;
      logic [7:0] b;
      int         x[4];
      int         gap;
   } vec_t;
   vec_t vecs[7];

   lcd_i2c_nibbler_if i2c_bus();

   always #5 clk = ~clk;

   lcd_i2c_nibbler #(
      .I2C_ADDR (7'h27),
      .BACKLIGHT(1'b1),
      .PWRUP_CYC(PWRUP),
      .INIT_CYC (INITC),
      .CMD_CYC  (CMDC),
      .CLR_CYC  (CLRC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_rs   (cmd_rs),
      .cmd_byte (cmd_byte),
      .i2c      (i2c_bus),
      .init_done(init_done)
`ifdef LCD_CURSOR_TRACK_EN
      ,
      .cur_row  (cur_row),
      .cur_col  (cur_col)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: backpack byte = nibble*16 + BL(8) + EN(4) + RS.
   task automatic model_xfers(input logic rs, input int b, output int e[4]);
      int hi, lo;
      hi = (b / 16) % 16;
      lo = b % 16;
      e[0] = hi * 16 + 8 + 4 + int'(rs);
      e[1] = hi * 16 + 8 + int'(rs);
      e[2] = lo * 16 + 8 + 4 + int'(rs);
      e[3] = lo * 16 + 8 + int'(rs);
   endtask

   function automatic int model_delay(input logic rs, input int b);
      return (!rs && b >= 1 && b <= 3) ? CLRC : CMDC;
   endfunction

   task automatic wait_ready(output int lat);
      lat = 0;
      while (!cmd_ready && lat < LIMIT) begin
         tick();
         lat++;
      end
   endtask

   // Waits for i2c_valid, then captures n back-to-back transfers (i2c_ready held high).
   task automatic check_group(input string name, input int e[4], input int n, input int exp_lat);
      int lat;
      int got;
      lat = 0;
      while (!i2c_bus.i2c_valid && lat < LIMIT) begin
         tick();
         lat++;
      end
      chk($sformatf("%s latency", name), lat, exp_lat);
      for (int k = 0; k < n; k++) begin
         got = i2c_bus.i2c_valid ? int'(i2c_bus.i2c_data) : -1;
         chk($sformatf("%s xfer%0d", name, k), got, e[k]);
         tick();
      end
   endtask

   task automatic run_init(input int first_lat);
      int e[4];
      int prev;
      int lat;
      prev = first_lat;
      for (int s = 0; s < 8; s++) begin
         model_xfers(1'b0, init_b[s], e);
         check_group($sformatf("init%0d", s), e, (init_nib[s] != 0) ? 2 : 4, prev);
         chk($sformatf("init%0d init_done", s), int'(init_done), 0);
         prev = init_dly[s];
      end
      wait_ready(lat);
      chk("init final gap", lat, prev);
      chk("init_done high", int'(init_done), 1);
      chk("init cmd_ready", int'(cmd_ready), 1);
   endtask

   task automatic send_and_check(input string name, input logic rs, input logic [7:0] b,
                                 input int e[4], input int egap);
      int lat;
      int final_gap;
      final_gap = egap;
      chk($sformatf("%s ready before", name), int'(cmd_ready), 1);
      cmd_rs    = rs;
      cmd_byte  = b;
      cmd_valid = 1'b1;
      tick();
      // Junk offered while busy must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_rs    = 1'($urandom);
      cmd_byte  = 8'($urandom);
      chk($sformatf("%s ready drop", name), int'(cmd_ready), 0);
      check_group(name, e, 4, 0);
      cmd_valid = 1'b0;
`ifdef LCD_CURSOR_TRACK_EN
      begin
         bit auto_cmd;
         int ae[4];
         auto_cmd = 1'b0;
         if (rs) begin
            if (m_col == 15) begin
               m_col    = 0;
               m_row    = 1 - m_row;
               auto_cmd = 1'b1;
            end else begin
               m_col++;
            end
         end else if (b[7]) begin
            m_row = int'(b[6]);
            m_col = int'(b[3:0]);
         end else if (b >= 8'h01 && b <= 8'h03) begin
            m_row = 0;
            m_col = 0;
         end
         if (auto_cmd) begin
            model_xfers(1'b0, 128 + m_row * 64, ae);
            check_group($sformatf("%s autopos", name), ae, 4, egap);
            final_gap = CMDC;
         end
      end
`endif
      wait_ready(lat);
      chk($sformatf("%s gap", name), lat, final_gap);
   endtask

   initial begin
      int lat;
      int e[4];
      logic rs;
      logic [7:0] b;

      vecs[0] = '{rs: 1'b1, b: 8'h41, x: '{'h4D, 'h49, 'h1D, 'h19}, gap: 4};
      vecs[1] = '{rs: 1'b0, b: 8'h01, x: '{'h0C, 'h08, 'h1C, 'h18}, gap: 8};
      vecs[2] = '{rs: 1'b0, b: 8'h03, x: '{'h0C, 'h08, 'h3C, 'h38}, gap: 8};
      vecs[3] = '{rs: 1'b0, b: 8'h04, x: '{'h0C, 'h08, 'h4C, 'h48}, gap: 4};
      vecs[4] = '{rs: 1'b0, b: 8'h00, x: '{'h0C, 'h08, 'h0C, 'h08}, gap: 4};
      vecs[5] = '{rs: 1'b1, b: 8'h7A, x: '{'h7D, 'h79, 'hAD, 'hA9}, gap: 4};
      vecs[6] = '{rs: 1'b1, b: 8'h02, x: '{'h0D, 'h09, 'h2D, 'h29}, gap: 4};

      i2c_bus.i2c_ready = 1'b1;
      rst = 1'b0;
      repeat (3) tick();
      chk("reset cmd_ready", int'(cmd_ready), 0);
      chk("reset i2c_valid", int'(i2c_bus.i2c_valid), 0);
      chk("reset i2c_data", int'(i2c_bus.i2c_data), 0);
      chk("reset init_done", int'(init_done), 0);
      chk("i2c_addr", int'(i2c_bus.i2c_addr), 'h27);
      rst = 1'b1;
      run_init(PWRUP);

      // Backpressure on the second transfer of 'A'.
      cmd_rs = 1'b1;
      cmd_byte = 8'h41;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("bp xfer0", int'(i2c_bus.i2c_data), 'h4D);
      tick();
      chk("bp xfer1", int'(i2c_bus.i2c_data), 'h49);
      i2c_bus.i2c_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("bp stall%0d valid", i), int'(i2c_bus.i2c_valid), 1);
         chk($sformatf("bp stall%0d data", i), int'(i2c_bus.i2c_data), 'h49);
      end
      i2c_bus.i2c_ready = 1'b1;
      tick();
      chk("bp xfer2", int'(i2c_bus.i2c_data), 'h1D);
      tick();
      chk("bp xfer3", int'(i2c_bus.i2c_data), 'h19);
      tick();
      wait_ready(lat);
      chk("bp gap", lat, 4);
`ifdef LCD_CURSOR_TRACK_EN
      m_col = 1;
`endif

      for (int v = 0; v < 7; v++)
         send_and_check($sformatf("vec%0d", v), vecs[v].rs, vecs[v].b, vecs[v].x, vecs[v].gap);

      for (int r = 0; r < 20; r++) begin
         rs = 1'($urandom_range(0, 1));
         b  = 8'($urandom);
         if (r % 4 == 3) begin
            rs = 1'b0;
            b  = 8'($urandom_range(1, 3));
         end
         model_xfers(rs, int'(b), e);
         send_and_check($sformatf("rnd%0d", r), rs, b, e, model_delay(rs, int'(b)));
      end

      // Reset during the third transfer of 'B'.
      cmd_rs = 1'b1;
      cmd_byte = 8'h42;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("rstmid xfer2", int'(i2c_bus.i2c_data), 'h2D);
      rst = 1'b0;
      tick();
      chk("rstmid i2c_valid", int'(i2c_bus.i2c_valid), 0);
      chk("rstmid cmd_ready", int'(cmd_ready), 0);
      chk("rstmid init_done", int'(init_done), 0);
      rst = 1'b1;
      run_init(PWRUP);

`ifdef LCD_CURSOR_TRACK_EN
      m_row = 0;
      m_col = 0;
      for (int c = 0; c < 16; c++) begin
         model_xfers(1'b1, 'h30 + c, e);
         send_and_check($sformatf("cur%0d", c), 1'b1, 8'(8'h30 + c), e, CMDC);
      end
      chk("cur_row after wrap", int'(cur_row), 1);
      chk("cur_col after wrap", int'(cur_col), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
